icache_fill: RTL and testbench
==============================

# icache_fill

Refill engine for the instruction cache. On a miss it claims the shared byte-wide RAM port, reads one aligned cache block byte by byte, assembles it little-endian, then presents the block with a one-cycle write-enable to the cache. It sits between the fetch/miss logic and the memory arbiter, directly upstream of the cache's `we`/`block` write port.

## Interface
- `BLOCK_BYTES`, 16: bytes per cache block; power of two, at least 4. `OFF = log2(BLOCK_BYTES)`.
- `clk_in` in 1: clock; all state changes on its rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: global ready; low stalls the block.
- `miss_valid` in 1: fetch reports a cache miss this cycle.
- `miss_addr` in 32: byte address of the missing instruction.
- `flush` in 1: branch-mispredict/clear; aborts an in-progress fill.
- `mem_gnt` in 1: arbiter grants the RAM port to this block.
- `mem_din` in 8: RAM read data, valid one cycle after its address.
- `mem_req` out 1: request/hold of the RAM port.
- `mem_a` out 32: RAM address.
- `mem_wr` out 1: RAM write strobe; constant 0.
- `busy` out 1: high whenever state is not IDLE.
- `we` out 1: one-cycle cache write-enable.
- `block` out 8*BLOCK_BYTES: assembled block; byte k at `[8k+7:8k]`.
- `fill_addr` out 32: aligned base address of `block`, low OFF bits zero.

## Operation
- Reset values: all outputs are 0. State is IDLE and counters are 0.
- Registers:
  - `base` holds the aligned address: `miss_addr` with its low OFF bits cleared.
  - `issue_cnt` and `recv_cnt` are OFF+1 bits wide, ranging 0..BLOCK_BYTES.
- IDLE:
  - `miss_valid` with `!flush` latches `base` and goes to REQ.
  - `miss_valid` is ignored in every other state; fetch must hold it or re-present it after `busy` falls.
- REQ:
  - `mem_req` is 1.
  - When `mem_gnt` is 1, clear both counters and go to READ.
- READ:
  - `mem_req` is 1.
  - While `issue_cnt < BLOCK_BYTES`: `mem_a = base + issue_cnt`, and `issue_cnt` increments.
  - Otherwise `mem_a = 0`.
  - Each cycle after an issue, `mem_din` is written into byte `recv_cnt` of the block register, and `recv_cnt` increments.
  - When `recv_cnt` reaches BLOCK_BYTES, go to WB.
- WB:
  - `we` is 1 for exactly this cycle; `block` and `fill_addr` are stable.
  - `mem_req` is 0.
  - Next state is IDLE.
- `mem_a` is 0 in every cycle that is not an issue cycle.
- `flush` in IDLE, REQ or READ:
  - Next state is IDLE; `mem_req` drops in the following cycle.
  - No `we` is produced; partial data is discarded.
- `flush` in WB is ignored. The block is correct memory data and is written.
- `flush` together with `miss_valid` in IDLE: flush wins and no fill starts.
- `rdy_in` low:
  - State, counters and registers hold; `we` is forced to 0; no byte is captured.
  - Any byte in flight is discarded. On the first cycle after `rdy_in` returns, `issue_cnt` is reloaded from `recv_cnt`, so byte `recv_cnt` is re-issued.
  - `mem_req` holds its value.
- `mem_gnt` is only sampled in REQ. In READ the arbiter must keep the grant while `mem_req` is high.

## Timing
- Miss seen at edge 0 (IDLE → REQ) with `mem_gnt` already high in cycle 1:
  - READ runs cycles 2..2+BLOCK_BYTES; the last cycle only receives.
  - WB is in cycle 3+BLOCK_BYTES. For BLOCK_BYTES=16, `we` is high in cycle 19.
- Each cycle of grant delay adds exactly one cycle. Each stalled cycle adds one cycle, plus one for the re-issue.
- Back-to-back: a new miss can be accepted in the first IDLE cycle after WB.
- `busy` is registered-state derived: high from the cycle after the miss is accepted through the WB cycle.

## Test plan
- Basic fill, BLOCK_BYTES=16:
  - Stimulus: `miss_addr=0x0000_1234` with immediate grant; RAM returns byte value = address[7:0].
  - Response: `mem_a` runs 0x1230..0x123F; `we` is high in cycle 19 only; `fill_addr=0x1230`; `block[7:0]=0x30`; `block[127:120]=0x3F`.
- Grant delay:
  - Stimulus: `mem_gnt` held low for 5 cycles.
  - Response: `mem_a` stays 0 and `mem_req` stays 1 throughout; `we` arrives 5 cycles later than in the basic test, with identical data.
- Flush mid-READ:
  - Stimulus: `flush` after 7 bytes are received.
  - Response: next state IDLE, `mem_req` 0 the following cycle, no `we`. A new miss to 0x2000 then produces a clean block from 0x2000..0x200F.
- Stall:
  - Stimulus: `rdy_in` low for 3 cycles after byte 4 has been issued.
  - Response: byte 4 is re-issued after resume; the block matches the basic test; `we` is delayed by exactly 4 cycles.
- Flush vs WB, and flush vs miss:
  - Stimulus 1: `flush` asserted in the WB cycle. Response: `we` is still 1.
  - Stimulus 2: `flush` together with `miss_valid` in IDLE. Response: `busy` stays 0.
- Reset mid-fill:
  - Stimulus: `rst_in` asserted in READ.
  - Response: the next cycle has all outputs 0, state IDLE, and no `we` ever appears for the aborted fill.

Source files
------------

// File: rtl/icache_fill.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fill
//  Purpose  : Instruction-cache refill engine. Reads one aligned block over a
//             byte-wide RAM port and writes it to the cache in a single cycle.
//  Revision : 1.0  initial release
// ============================================================================
module icache_fill #(
    parameter int unsigned BLOCK_BYTES = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       miss_valid,
    input  logic [31:0]                miss_addr,
    input  logic                       flush,
    input  logic                       mem_gnt,
    input  logic [7:0]                 mem_din,
    output logic                       mem_req,
    output logic [31:0]                mem_a,
    output logic                       mem_wr,
    output logic                       busy,
    output logic                       we,
    output logic [8*BLOCK_BYTES-1:0]   block,
    output logic [31:0]                fill_addr
);

    localparam int unsigned      c_off       = $clog2(BLOCK_BYTES);
    localparam logic [c_off:0]   c_full      = (c_off+1)'(BLOCK_BYTES);
    localparam logic [c_off:0]   c_last      = (c_off+1)'(BLOCK_BYTES - 1);
    localparam logic [c_off:0]   c_one       = (c_off+1)'(1);
    localparam logic [31:0]      c_base_mask = ~(32'(BLOCK_BYTES - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_READ = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [31:0]                r_base;
    logic [c_off:0]             r_issue_cnt;
    logic [c_off:0]             r_recv_cnt;
    logic                       r_inflight;
    logic                       r_resume;
    logic [8*BLOCK_BYTES-1:0]   r_block;

    logic [c_off:0]             w_issue_idx;
    logic                       w_issue;
    logic                       w_capture;

    // After a stall the in-flight byte was dropped, so issuing restarts at
    // the first byte not yet received.
    always_comb begin
        w_issue_idx = r_resume ? r_recv_cnt : r_issue_cnt;
        w_issue     = (r_state == S_READ) && rdy_in && (w_issue_idx < c_full);
        w_capture   = (r_state == S_READ) && rdy_in && r_inflight;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A flush aborts even while stalled; only a completed block in WB survives it.
    always_comb begin
        w_next_state = r_state;
        if (flush && (r_state != S_WB)) begin
            w_next_state = S_IDLE;
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE:  if (miss_valid) w_next_state = S_REQ;
                S_REQ:   if (mem_gnt) w_next_state = S_READ;
                S_READ:  if (w_capture && (r_recv_cnt == c_last)) w_next_state = S_WB;
                S_WB:    w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_resume    <= 1'b0;
            r_block     <= '0;
        end else begin
            r_resume <= !rdy_in;
            if (!rdy_in) begin
                r_inflight <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (miss_valid && !flush) begin
                            r_base <= miss_addr & c_base_mask;
                        end
                    end
                    S_REQ: begin
                        if (mem_gnt) begin
                            r_issue_cnt <= '0;
                            r_recv_cnt  <= '0;
                            r_inflight  <= 1'b0;
                        end
                    end
                    S_READ: begin
                        r_issue_cnt <= w_issue ? (w_issue_idx + c_one) : w_issue_idx;
                        r_inflight  <= w_issue;
                        if (w_capture) begin
                            r_block[8*r_recv_cnt[c_off-1:0] +: 8] <= mem_din;
                            r_recv_cnt <= r_recv_cnt + c_one;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        mem_req   = (r_state == S_REQ) || (r_state == S_READ);
        mem_a     = w_issue ? (r_base + 32'(w_issue_idx)) : 32'd0;
        mem_wr    = 1'b0;
        busy      = (r_state != S_IDLE);
        we        = (r_state == S_WB) && rdy_in;
        block     = r_block;
        fill_addr = r_base;
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_fill.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_fill
//  Purpose  : Directed self-checking bench for icache_fill (BLOCK_BYTES=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache_fill;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, miss_valid, flush, mem_gnt;
    logic [31:0]   miss_addr;
    logic [7:0]    mem_din = 8'h00;
    logic          mem_req, mem_wr, busy, we;
    logic [31:0]   mem_a, fill_addr;
    logic [127:0]  block;

    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            we_cnt = 0;
    int            we_cyc = 0;
    int            t0 = 0;
    int            base_we;
    logic [127:0]  we_block = '0;
    logic [31:0]   we_addr = '0;
    bit            log_en = 1'b0;
    int            iss_cyc[$];
    logic [31:0]   iss_addr[$];

    localparam logic [127:0] BLK_1230 = 128'h3F3E3D3C3B3A39383736353433323130;
    localparam logic [127:0] BLK_2000 = 128'h0F0E0D0C0B0A09080706050403020100;

    icache_fill #(.BLOCK_BYTES(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .flush(flush),
        .mem_gnt(mem_gnt), .mem_din(mem_din), .mem_req(mem_req),
        .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy), .we(we),
        .block(block), .fill_addr(fill_addr)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: byte value equals low address byte, one cycle latency.
    always @(posedge clk_in) begin
        cyc     <= cyc + 1;
        mem_din <= mem_a[7:0];
    end

    always @(negedge clk_in) begin
        if (we) begin
            we_cnt   <= we_cnt + 1;
            we_cyc   <= cyc;
            we_block <= block;
            we_addr  <= fill_addr;
        end
        if (log_en && (mem_a != 32'd0)) begin
            iss_addr.push_back(mem_a);
            iss_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic start_miss(input logic [31:0] addr);
        miss_valid = 1'b1;
        miss_addr  = addr;
        t0         = cyc;
        adv(1);
        miss_valid = 1'b0;
    endtask

    task automatic wait_we(input int budget);
        int start;
        bit got;
        start = we_cnt;
        got   = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk_in);
            #1;
            if (we_cnt != start) got = 1'b1;
        end
        chk("we_seen", 128'(got), 128'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 128'(mem_req), 128'(0));
        chk({tag, "_mem_a"}, 128'(mem_a), 128'(0));
        chk({tag, "_mem_wr"}, 128'(mem_wr), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_we"}, 128'(we), 128'(0));
        chk({tag, "_block"}, block, 128'(0));
        chk({tag, "_fill_addr"}, 128'(fill_addr), 128'(0));
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; miss_valid = 1'b0; flush = 1'b0;
        mem_gnt = 1'b1; miss_addr = 32'd0;

        // Reset state
        adv(3);
        @(negedge clk_in);
        chk_all_zero("reset");
        adv(1);
        rst_in = 1'b0;
        adv(1);

        // Basic fill
        log_en = 1'b1;
        start_miss(32'h0000_1234);
        @(negedge clk_in);
        chk("basic_busy_req", 128'(busy), 128'(1));
        chk("basic_mem_req_req", 128'(mem_req), 128'(1));
        chk("basic_mem_a_req", 128'(mem_a), 128'(0));
        wait_we(40);
        log_en = 1'b0;
        chk("basic_we_cycle", 128'(we_cyc - t0), 128'(19));
        chk("basic_fill_addr", 128'(we_addr), 128'(32'h1230));
        chk("basic_block", we_block, BLK_1230);
        chk("basic_byte0", 128'(we_block[7:0]), 128'(8'h30));
        chk("basic_byte15", 128'(we_block[127:120]), 128'(8'h3F));
        chk("basic_issue_count", 128'(iss_addr.size()), 128'(16));
        for (int k = 0; k < iss_addr.size(); k++) begin
            chk($sformatf("basic_issue_addr%0d", k), 128'(iss_addr[k]), 128'(32'h1230 + k));
            chk($sformatf("basic_issue_cyc%0d", k), 128'(iss_cyc[k] - t0), 128'(2 + k));
        end
        adv(3);
        chk("basic_we_once", 128'(we_cnt), 128'(1));
        chk("basic_busy_after", 128'(busy), 128'(0));

        // Grant delay of 5 cycles
        mem_gnt = 1'b0;
        start_miss(32'h0000_1234);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk($sformatf("gnt_mem_req%0d", i), 128'(mem_req), 128'(1));
            chk($sformatf("gnt_mem_a%0d", i), 128'(mem_a), 128'(0));
            adv(1);
        end
        mem_gnt = 1'b1;
        wait_we(40);
        chk("gnt_we_cycle", 128'(we_cyc - t0), 128'(24));
        chk("gnt_block", we_block, BLK_1230);

        // Flush after 7 bytes received, then a clean fill from 0x2000
        base_we = we_cnt;
        start_miss(32'h0000_1234);
        adv(9);
        flush = 1'b1;
        adv(1);
        flush = 1'b0;
        @(negedge clk_in);
        chk("flush_busy", 128'(busy), 128'(0));
        chk("flush_mem_req", 128'(mem_req), 128'(0));
        adv(25);
        chk("flush_no_we", 128'(we_cnt), 128'(base_we));
        start_miss(32'h0000_2000);
        wait_we(40);
        chk("refill_we_cycle", 128'(we_cyc - t0), 128'(19));
        chk("refill_fill_addr", 128'(we_addr), 128'(32'h2000));
        chk("refill_block", we_block, BLK_2000);

        // Stall of 3 cycles right after byte 4 is issued
        start_miss(32'h0000_1234);
        adv(6);
        rdy_in = 1'b0;
        @(negedge clk_in);
        chk("stall_mem_a", 128'(mem_a), 128'(0));
        chk("stall_mem_req", 128'(mem_req), 128'(1));
        chk("stall_we", 128'(we), 128'(0));
        adv(3);
        rdy_in = 1'b1;
        @(negedge clk_in);
        chk("stall_reissue_addr", 128'(mem_a), 128'(32'h1234));
        wait_we(40);
        chk("stall_we_cycle", 128'(we_cyc - t0), 128'(23));
        chk("stall_block", we_block, BLK_1230);

        // Flush in the WB cycle is ignored
        base_we = we_cnt;
        start_miss(32'h0000_1234);
        adv(18);
        flush = 1'b1;
        @(negedge clk_in);
        chk("wbflush_we", 128'(we), 128'(1));
        adv(1);
        flush = 1'b0;
        @(negedge clk_in);
        chk("wbflush_we_count", 128'(we_cnt), 128'(base_we + 1));
        chk("wbflush_block", we_block, BLK_1230);
        chk("wbflush_busy_after", 128'(busy), 128'(0));

        // Flush together with a miss in IDLE
        base_we = we_cnt;
        adv(1);
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_3000;
        flush      = 1'b1;
        adv(1);
        miss_valid = 1'b0;
        flush      = 1'b0;
        @(negedge clk_in);
        chk("missflush_busy", 128'(busy), 128'(0));
        chk("missflush_mem_req", 128'(mem_req), 128'(0));
        adv(20);
        chk("missflush_no_we", 128'(we_cnt), 128'(base_we));

        // Reset asserted during READ
        base_we = we_cnt;
        start_miss(32'h0000_1234);
        adv(5);
        rst_in = 1'b1;
        adv(1);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_all_zero("midrst");
        adv(30);
        chk("midrst_no_we", 128'(we_cnt), 128'(base_we));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
